fifo_sync_param: RTL and testbench

//   Parametrised single-clock FIFO. Next generation of the 8x16 FIFO, with configurable

---
 rtl/fifo_sync_param.sv | 96 +++++++++
 tb/tb_fifo_sync_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty thresholds
// and sticky overflow/underflow flags. Define FIFO_FWFT_EN for first-word-fall-through output.
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              we,
  input  logic              re,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_TH   = (ADDR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0] AE_TH   = (ADDR_W+1)'(AE_MARGIN);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              rd_ok;
  logic              wr_ok;

  // Flags are pure decodes of the occupancy register.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);
  assign count        = count_q;

  // A read frees a slot in the same edge, so a full FIFO may accept a write alongside it.
  assign rd_ok = re && !empty;
  assign wr_ok = we && (!full || rd_ok);

  // NOTE: storage is deliberately left out of reset; clearing it would force flops where RAM suffices.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we && full && !rd_ok) overflow  <= 1'b1;
      if (re && empty)          underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible as soon as it is stored; forced to zero while empty.
  assign dout = empty ? '0 : mem[rd_ptr];
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= mem[rd_ptr];
    end
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (WIDTH=8, DEPTH=16, margins 2); honours FIFO_FWFT_EN.
module tb_fifo_sync_param;

`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       we  = 1'b0;
  logic       re  = 1'b0;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  fifo_sync_param #(.WIDTH(8), .DEPTH(DEPTH), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .din(din), .we(we), .re(re), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of stored words plus sticky flags and the last popped word.
  logic [7:0] q [$];
  logic       m_ovf, m_unf;
  logic [7:0] m_last;

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_last = '0;
  endtask

  task automatic model_update(input logic w, input logic r, input logic [7:0] d);
    bit was_empty = (q.size() == 0);
    bit was_full  = (q.size() == DEPTH);
    bit rd        = r && !was_empty;
    bit wr        = w && (!was_full || rd);
    if (w && was_full && !rd) m_ovf = 1'b1;
    if (r && was_empty)       m_unf = 1'b1;
    if (rd) m_last = q.pop_front();
    if (wr) q.push_back(d);
  endtask

  task automatic compare_model(input string tag);
    int n = q.size();
    check({tag, ".count"},        32'(count),        32'(n));
    check({tag, ".full"},         32'(full),         32'(n == DEPTH));
    check({tag, ".empty"},        32'(empty),        32'(n == 0));
    check({tag, ".almost_full"},  32'(almost_full),  32'(n >= DEPTH - 2));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 2));
    check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(m_unf));
    if (!FWFT)      check({tag, ".dout"}, 32'(dout), 32'(m_last));
    else if (n > 0) check({tag, ".dout"}, 32'(dout), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
    we = w; re = r; din = d;
    @(posedge clk);
    model_update(w, r, d);
    #1;
    compare_model(tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".count"},        32'(count),        32'd0);
    check({tag, ".empty"},        32'(empty),        32'd1);
    check({tag, ".full"},         32'(full),         32'd0);
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
    check({tag, ".almost_full"},  32'(almost_full),  32'd0);
    check({tag, ".overflow"},     32'(overflow),     32'd0);
    check({tag, ".underflow"},    32'(underflow),    32'd0);
    check({tag, ".dout"},         32'(dout),         32'd0);
  endtask

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] din;
    int         exp_count;
    logic       exp_full, exp_empty, exp_af, exp_ae, exp_ovf, exp_unf;
    logic       dout_chk;
    logic [7:0] exp_dout;
  } vec_t;

  localparam int NVEC = 34;
  vec_t vecs [NVEC];

  initial begin
    // Fill 0..15, overflow attempt with FF, drain 16, then one read from empty.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{we: 1'b1, re: 1'b0, din: 8'(i), exp_count: i + 1,
                  exp_full: (i + 1 == 16), exp_empty: 1'b0,
                  exp_af: (i + 1 >= 14), exp_ae: (i + 1 <= 2),
                  exp_ovf: 1'b0, exp_unf: 1'b0, dout_chk: 1'b1, exp_dout: 8'h00};
    end
    vecs[16] = '{we: 1'b1, re: 1'b0, din: 8'hFF, exp_count: 16, exp_full: 1'b1,
                 exp_empty: 1'b0, exp_af: 1'b1, exp_ae: 1'b0, exp_ovf: 1'b1,
                 exp_unf: 1'b0, dout_chk: 1'b1, exp_dout: 8'h00};
    for (int k = 0; k < 16; k++) begin
      vecs[17 + k] = '{we: 1'b0, re: 1'b1, din: 8'h00, exp_count: 15 - k,
                       exp_full: 1'b0, exp_empty: (k == 15),
                       exp_af: (15 - k >= 14), exp_ae: (15 - k <= 2),
                       exp_ovf: 1'b1, exp_unf: 1'b0,
                       dout_chk: !FWFT || (k < 15),
                       exp_dout: FWFT ? 8'(k + 1) : 8'(k)};
    end
    vecs[33] = '{we: 1'b0, re: 1'b1, din: 8'h00, exp_count: 0, exp_full: 1'b0,
                 exp_empty: 1'b1, exp_af: 1'b0, exp_ae: 1'b1, exp_ovf: 1'b1,
                 exp_unf: 1'b1, dout_chk: !FWFT, exp_dout: 8'd15};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      we = vecs[i].we; re = vecs[i].re; din = vecs[i].din;
      @(posedge clk);
      model_update(vecs[i].we, vecs[i].re, vecs[i].din);
      #1;
      check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d.flags", i),
            32'({full, empty, almost_full, almost_empty, overflow, underflow}),
            32'({vecs[i].exp_full, vecs[i].exp_empty, vecs[i].exp_af,
                 vecs[i].exp_ae, vecs[i].exp_ovf, vecs[i].exp_unf}));
      if (vecs[i].dout_chk)
        check($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].exp_dout));
    end
    we = 1'b0; re = 1'b0;

    // Pointers untouched by the underflow: the next write/read pair round-trips.
    step(1'b1, 1'b0, 8'h3C, "post_unf_wr");
    step(1'b0, 1'b1, 8'h00, "post_unf_rd");
    if (!FWFT) check("post_unf_data", 32'(dout), 32'h3C);

    // Simultaneous read and write while full, then while empty.
    rst = 1'b0; #1; model_reset(); check_reset_state("rst2");
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i), "fill2");
    step(1'b1, 1'b1, 8'hA5, "full_rw");
    check("full_rw.count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, "drain2");
    if (!FWFT) check("a5_last", 32'(dout), 32'hA5);
    step(1'b1, 1'b1, 8'h5A, "empty_rw");
    check("empty_rw.count", 32'(count), 32'd1);
    check("empty_rw.unf", 32'(underflow), 32'd1);
    step(1'b0, 1'b1, 8'h00, "empty_rw_pop");

    // Interleaved stream across the pointer wrap.
    rst = 1'b0; #1; model_reset();
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 26; i++) step(i < 20, i >= 6, 8'(8'h40 + i), "wrap");

    // Second stream with reset pulsed asynchronously between edges.
    for (int i = 0; i < 9; i++) step(1'b1, i >= 3, 8'(8'h80 + i), "pre_rst");
    #2 rst = 1'b0;
    #1 check_reset_state("async_rst");
    model_reset();
    @(posedge clk); #1;
    check_reset_state("async_rst_hold");
    rst = 1'b1;

    // Randomised traffic with phases biased toward filling and draining.
    for (int i = 0; i < 600; i++) begin
      int pw = ((i / 100) % 2 == 0) ? 75 : 30;
      logic w = ($urandom_range(0, 99) < pw);
      logic r = ($urandom_range(0, 99) < (100 - pw));
      step(w, r, 8'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
